// File: rtl/arith_pkg.sv
// Shared arithmetic-unit types and helpers for booth_multiplier and booth_divider.
package arith_pkg;

    localparam int ARITH_MAX_W = 128;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_e;

    // Magnitude of a sign-extended operand, one bit wider so |MIN| is representable.
    function automatic logic [ARITH_MAX_W:0] abs_ext(input logic [ARITH_MAX_W-1:0] v);
        logic [ARITH_MAX_W:0] x;
        x = {v[ARITH_MAX_W-1], v};
        return x[ARITH_MAX_W] ? -x : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step, purely combinational.
module div_step #(
    parameter int N = 64
) (
    input  logic [N:0]   r_i,
    input  logic [N-1:0] q_i,
    input  logic [N:0]   b_mag_i,
    output logic [N:0]   r_o,
    output logic [N-1:0] q_o
);
    logic [N:0]   r_shift;
    logic [N-1:0] q_shift;
    logic         unused_r_msb;

    // The partial remainder stays below |b| <= 2^(N-1), so its top bit is always zero here.
    assign unused_r_msb = r_i[N];
    assign r_shift      = {r_i[N-1:0], q_i[N-1]};
    assign q_shift      = {q_i[N-2:0], 1'b0};

    always_comb begin
        r_o = r_shift;
        q_o = q_shift;
        if (r_shift >= b_mag_i) begin
            r_o = r_shift - b_mag_i;
            q_o = q_shift | {{(N-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/booth_divider.sv
// Signed N-bit divider (truncating), done N+1 edges after accept or 1 edge on b==0; start ignored while busy.
// DIVIDER_OVF_FLAG_EN adds the overflow output flagging MIN / -1.
module booth_divider
    import arith_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
`ifdef DIVIDER_OVF_FLAG_EN
    ,
    output logic         overflow
`endif
);
    localparam int CW = $clog2(N + 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N:0]       r_q, r_d;
    logic [N-1:0]     qw_q, qw_d;
    logic [N:0]       bmag_q, bmag_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [N-1:0]     quo_q, quo_d;
    logic [N-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [ARITH_MAX_W:0] a_abs_w, b_abs_w;
    logic [N:0]           a_mag, b_mag;
    logic                 unused_abs;
    logic [N:0]           step_r;
    logic [N-1:0]         step_q;
    logic [N-1:0]         r_lo;

    assign a_abs_w    = abs_ext(ARITH_MAX_W'($signed(dividend)));
    assign b_abs_w    = abs_ext(ARITH_MAX_W'($signed(divisor)));
    assign a_mag      = a_abs_w[N:0];
    assign b_mag      = b_abs_w[N:0];
    assign unused_abs = ^{a_abs_w, b_abs_w};
    assign r_lo       = r_q[N-1:0];

    div_step #(.N(N)) u_step (
        .r_i     (r_q),
        .q_i     (qw_q),
        .b_mag_i (bmag_q),
        .r_o     (step_r),
        .q_o     (step_q)
    );

`ifdef DIVIDER_OVF_FLAG_EN
    logic ovf_pend_q, ovf_pend_d;
    logic ovf_q, ovf_d;
    assign overflow = ovf_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        qw_d       = qw_q;
        bmag_d     = bmag_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        dbz_pend_d = dbz_pend_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
`ifdef DIVIDER_OVF_FLAG_EN
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d       = dividend[N-1];
                    sb_d       = divisor[N-1];
                    bmag_d     = b_mag;
                    qw_d       = a_mag[N-1:0];
                    r_d        = '0;
                    cnt_d      = '0;
                    dbz_pend_d = (divisor == '0);
`ifdef DIVIDER_OVF_FLAG_EN
                    ovf_pend_d = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
`endif
                    // Divide-by-zero skips the iterations; FIX then publishes -1 and a.
                    state_d    = (divisor == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                r_d   = step_r;
                qw_d  = step_q;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dbz_pend_q) begin
                    quo_d = '1;
                    rem_d = sa_q ? -qw_q : qw_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = (sa_q ^ sb_q) ? -qw_q : qw_q;
                    rem_d = sa_q ? -r_lo : r_lo;
                    dbz_d = 1'b0;
                end
`ifdef DIVIDER_OVF_FLAG_EN
                ovf_d = ovf_pend_q;
`endif
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            qw_q       <= '0;
            bmag_q     <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            dbz_pend_q <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
`ifdef DIVIDER_OVF_FLAG_EN
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            qw_q       <= qw_d;
            bmag_q     <= bmag_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            dbz_pend_q <= dbz_pend_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
`ifdef DIVIDER_OVF_FLAG_EN
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule
